axi4_full_arbiter: RTL and testbench
====================================

// Module: axi4_full_arbiter
// PURPOSE
// - Shares one axi4_full_slave port between NUM_M AXI4 masters.
// - Independent write-path and read-path arbiters, each round-robin.
// - No ID signals exist, so each path holds its grant for a whole transaction:
//   - write: AW, then W burst, then B;
//   - read: AR, then R burst to RLAST.
// - Sits between the masters (DMA, CPU bridge) and the memory slave.
// PARAMETERS
// - ADDR_WIDTH  32    address width, same as the slave.
// - DATA_WIDTH  32    data width, same as the slave.
// - NUM_M       2     number of masters, >=2; GW = $clog2(NUM_M).
// PORTS (m_* packed per master: bit/field i belongs to master i)
// - ACLK       in   1        clock
// - ARESET     in   1        asynchronous reset, active-high
// - m_awaddr in NUM_M*ADDR_WIDTH, m_awlen in NUM_M*8, m_awsize in NUM_M*3
// - m_awvalid in NUM_M, m_awready out NUM_M   (master AW channels)
// - m_wdata in NUM_M*DATA_WIDTH, m_wvalid/m_wlast in NUM_M, m_wready out NUM_M
// - m_bresp out NUM_M*2, m_bvalid out NUM_M, m_bready in NUM_M
// - m_araddr in NUM_M*ADDR_WIDTH, m_arlen in NUM_M*8, m_arsize in NUM_M*3
// - m_arvalid in NUM_M, m_arready out NUM_M   (master AR channels)
// - m_rdata out NUM_M*DATA_WIDTH, m_rvalid/m_rlast out NUM_M, m_rready in NUM_M
// - s_aw*/s_w*/s_b*/s_ar*/s_r*: same widths, single port, opposite directions
// - wr_gnt out GW, rd_gnt out GW   current/last granted master per path
// - wr_busy out 1, rd_busy out 1   path state != IDLE
// BEHAVIOUR
// - Reset (async, ARESET=1), all paths:
//   - States go to IDLE; wr_gnt = rd_gnt = 0; rr pointers wr_last = rd_last = NUM_M-1.
//   - So master 0 has first priority.
//   - All valid/ready outputs, both sides, are 0.
//   - Data, resp and last outputs are 0.
// - Write FSM, W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE:
//   - W_IDLE: all m_awready/m_wready/m_bvalid and s_awvalid/s_wvalid/s_bready are 0.
//     - If any m_awvalid: wr_gnt <= first requester searching wr_last+1, wr_last+2, ...
//       mod NUM_M; go to W_ADDR.
//   - W_ADDR: s_aw* = m_aw*[wr_gnt]; m_awready[wr_gnt] = s_awready.
//     - On s_awvalid & s_awready: go to W_DATA.
//   - W_DATA: s_w* = m_w*[wr_gnt]; m_wready[wr_gnt] = s_wready.
//     - On a beat with wlast: go to W_RESP.
//   - W_RESP: m_bvalid[wr_gnt] = s_bvalid; m_bresp[wr_gnt] = s_bresp;
//     s_bready = m_bready[wr_gnt].
//     - On B handshake: wr_last <= wr_gnt; go to W_IDLE.
// - Read FSM, R_IDLE -> R_ADDR -> R_DATA -> R_IDLE:
//   - Same scheme using ar*/r* and rd_gnt/rd_last.
//   - Leaves R_DATA on s_rvalid & s_rready & s_rlast.
// - Routing: channel muxes are combinational from the registered state and grant.
//   - Non-granted masters always see ready = 0 and valid = 0.
//   - Their data/resp/last outputs are 0.
// - Latency: request in IDLE to s_awvalid/s_arvalid is 1 cycle; after that, zero added latency.
// - Masters must hold AWVALID/ARVALID until accepted (AXI rule), so the grant is stable.
// - Early WVALID, before AW is accepted, is stalled with wready = 0 and never forwarded.
// - Read and write paths are fully independent.
//   - They may serve different or the same master concurrently.
//   - Simultaneous requests on both paths are both granted in the same cycle.
// - Only one outstanding transaction per path; new AW/AR is blocked until B/RLAST completes.
// - A master deasserting its request at the moment of arbitration is not a legal AXI case.
//   - No recovery is required for it.
// - Reset mid-burst: immediate return to IDLE, all valids dropped the same cycle.
//   - Pointers are reinitialised.
// TESTING
// - Single master, M0 AW addr=0x10 len=3 size=2 + 4 beats, then B:
//   - slave mem words 4..7 are written.
//   - m_bvalid[0] pulses with bresp 00.
//   - m_awready[1] stays 0 throughout.
// - M0 and M1 assert AWVALID in the same cycle from reset:
//   - M0 is granted first, then M1.
//   - Repeat with both requesting again: M0, M1 alternate.
//   - wr_gnt sequence is 0,1,0,1.
// - M1 reads len=7 while M0 writes len=3:
//   - both complete concurrently;
//   - M1 gets 8 beats with rlast on beat 8 only;
//   - rd_gnt = 1, wr_gnt = 0.
// - Slave holds BREADY-side backpressure (m_bready[0] = 0 for 5 cycles):
//   - M1 AW is not accepted until M0 B completes.
// - M0 asserts WVALID 3 cycles before AWVALID:
//   - m_wready[0] = 0 until AW handshake;
//   - data lands at the AW address.
// - ARESET pulsed mid read burst (beat 2 of 4):
//   - all m_rvalid and s_arvalid are 0 that cycle;
//   - after release, a new M0 read completes normally.

Source files
------------

// File: rtl/axi4_full_arbiter.sv
// Shares one AXI4 slave port between NUM_M masters. Write and read paths
// each run a round-robin arbiter and keep the grant for a full transaction.
module axi4_full_arbiter #(
    parameter int  ADDR_WIDTH = 32,
    parameter int  DATA_WIDTH = 32,
    parameter int  NUM_M      = 2,
    localparam int GW         = $clog2(NUM_M)
) (
    input  logic                          ACLK,
    input  logic                          ARESET,

    input  logic [NUM_M*ADDR_WIDTH-1:0]   m_awaddr,
    input  logic [NUM_M*8-1:0]            m_awlen,
    input  logic [NUM_M*3-1:0]            m_awsize,
    input  logic [NUM_M-1:0]              m_awvalid,
    output logic [NUM_M-1:0]              m_awready,
    input  logic [NUM_M*DATA_WIDTH-1:0]   m_wdata,
    input  logic [NUM_M-1:0]              m_wvalid,
    input  logic [NUM_M-1:0]              m_wlast,
    output logic [NUM_M-1:0]              m_wready,
    output logic [NUM_M*2-1:0]            m_bresp,
    output logic [NUM_M-1:0]              m_bvalid,
    input  logic [NUM_M-1:0]              m_bready,
    input  logic [NUM_M*ADDR_WIDTH-1:0]   m_araddr,
    input  logic [NUM_M*8-1:0]            m_arlen,
    input  logic [NUM_M*3-1:0]            m_arsize,
    input  logic [NUM_M-1:0]              m_arvalid,
    output logic [NUM_M-1:0]              m_arready,
    output logic [NUM_M*DATA_WIDTH-1:0]   m_rdata,
    output logic [NUM_M-1:0]              m_rvalid,
    output logic [NUM_M-1:0]              m_rlast,
    input  logic [NUM_M-1:0]              m_rready,

    output logic [ADDR_WIDTH-1:0]         s_awaddr,
    output logic [7:0]                    s_awlen,
    output logic [2:0]                    s_awsize,
    output logic                          s_awvalid,
    input  logic                          s_awready,
    output logic [DATA_WIDTH-1:0]         s_wdata,
    output logic                          s_wvalid,
    output logic                          s_wlast,
    input  logic                          s_wready,
    input  logic [1:0]                    s_bresp,
    input  logic                          s_bvalid,
    output logic                          s_bready,
    output logic [ADDR_WIDTH-1:0]         s_araddr,
    output logic [7:0]                    s_arlen,
    output logic [2:0]                    s_arsize,
    output logic                          s_arvalid,
    input  logic                          s_arready,
    input  logic [DATA_WIDTH-1:0]         s_rdata,
    input  logic                          s_rvalid,
    input  logic                          s_rlast,
    output logic                          s_rready,

    output logic [GW-1:0]                 wr_gnt,
    output logic [GW-1:0]                 rd_gnt,
    output logic                          wr_busy,
    output logic                          rd_busy
);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

    wr_state_t     wr_state, wr_state_nxt;
    rd_state_t     rd_state, rd_state_nxt;
    logic [GW-1:0] wr_last, wr_last_nxt, wr_gnt_nxt;
    logic [GW-1:0] rd_last, rd_last_nxt, rd_gnt_nxt;

    // Nearest requester after 'last' wins; the loop runs far-to-near so the
    // closest one overwrites any earlier candidate.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_M-1:0] req,
                                              input logic [GW-1:0]    last);
        logic [GW-1:0] pick;
        int            idx;
        pick = last;
        for (int k = NUM_M; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_M;
            if (req[idx]) pick = GW'(idx);
        end
        return pick;
    endfunction

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state <= W_IDLE;
            wr_gnt   <= '0;
            wr_last  <= GW'(NUM_M - 1);
            rd_state <= R_IDLE;
            rd_gnt   <= '0;
            rd_last  <= GW'(NUM_M - 1);
        end else begin
            wr_state <= wr_state_nxt;
            wr_gnt   <= wr_gnt_nxt;
            wr_last  <= wr_last_nxt;
            rd_state <= rd_state_nxt;
            rd_gnt   <= rd_gnt_nxt;
            rd_last  <= rd_last_nxt;
        end
    end

    always_comb begin
        wr_state_nxt = wr_state;
        wr_gnt_nxt   = wr_gnt;
        wr_last_nxt  = wr_last;
        s_awaddr     = '0;
        s_awlen      = '0;
        s_awsize     = '0;
        s_awvalid    = 1'b0;
        s_wdata      = '0;
        s_wvalid     = 1'b0;
        s_wlast      = 1'b0;
        s_bready     = 1'b0;
        m_awready    = '0;
        m_wready     = '0;
        m_bvalid     = '0;
        m_bresp      = '0;
        case (wr_state)
            W_IDLE: begin
                if (|m_awvalid) begin
                    wr_gnt_nxt   = rr_pick(m_awvalid, wr_last);
                    wr_state_nxt = W_ADDR;
                end
            end
            W_ADDR: begin
                s_awaddr          = m_awaddr[int'(wr_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
                s_awlen           = m_awlen[int'(wr_gnt)*8 +: 8];
                s_awsize          = m_awsize[int'(wr_gnt)*3 +: 3];
                s_awvalid         = m_awvalid[wr_gnt];
                m_awready[wr_gnt] = s_awready;
                if (m_awvalid[wr_gnt] && s_awready) wr_state_nxt = W_DATA;
            end
            W_DATA: begin
                s_wdata          = m_wdata[int'(wr_gnt)*DATA_WIDTH +: DATA_WIDTH];
                s_wvalid         = m_wvalid[wr_gnt];
                s_wlast          = m_wlast[wr_gnt];
                m_wready[wr_gnt] = s_wready;
                if (m_wvalid[wr_gnt] && s_wready && m_wlast[wr_gnt]) wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                s_bready                       = m_bready[wr_gnt];
                m_bvalid[wr_gnt]               = s_bvalid;
                m_bresp[int'(wr_gnt)*2 +: 2]   = s_bresp;
                if (s_bvalid && m_bready[wr_gnt]) begin
                    wr_last_nxt  = wr_gnt;
                    wr_state_nxt = W_IDLE;
                end
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_nxt = rd_state;
        rd_gnt_nxt   = rd_gnt;
        rd_last_nxt  = rd_last;
        s_araddr     = '0;
        s_arlen      = '0;
        s_arsize     = '0;
        s_arvalid    = 1'b0;
        s_rready     = 1'b0;
        m_arready    = '0;
        m_rdata      = '0;
        m_rvalid     = '0;
        m_rlast      = '0;
        case (rd_state)
            R_IDLE: begin
                if (|m_arvalid) begin
                    rd_gnt_nxt   = rr_pick(m_arvalid, rd_last);
                    rd_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                s_araddr          = m_araddr[int'(rd_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
                s_arlen           = m_arlen[int'(rd_gnt)*8 +: 8];
                s_arsize          = m_arsize[int'(rd_gnt)*3 +: 3];
                s_arvalid         = m_arvalid[rd_gnt];
                m_arready[rd_gnt] = s_arready;
                if (m_arvalid[rd_gnt] && s_arready) rd_state_nxt = R_DATA;
            end
            R_DATA: begin
                s_rready                                      = m_rready[rd_gnt];
                m_rvalid[rd_gnt]                              = s_rvalid;
                m_rlast[rd_gnt]                               = s_rlast;
                m_rdata[int'(rd_gnt)*DATA_WIDTH +: DATA_WIDTH] = s_rdata;
                if (s_rvalid && m_rready[rd_gnt] && s_rlast) begin
                    rd_last_nxt  = rd_gnt;
                    rd_state_nxt = R_IDLE;
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    assign wr_busy = (wr_state != W_IDLE);
    assign rd_busy = (rd_state != R_IDLE);

endmodule

// File: tb/tb_axi4_full_arbiter.sv
// Bench for axi4_full_arbiter: random AXI masters and a memory slave around
// the DUT, checked against a transaction-level ownership/round-robin model.
module tb_axi4_full_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int NM        = 2;
    localparam int MEM_WORDS = 512;
    localparam int RD_BASE   = 256;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [NM*AW-1:0]  m_awaddr, m_araddr;
    logic [NM*8-1:0]   m_awlen, m_arlen;
    logic [NM*3-1:0]   m_awsize, m_arsize;
    logic [NM-1:0]     m_awvalid, m_awready, m_wvalid, m_wlast, m_wready;
    logic [NM-1:0]     m_bvalid, m_bready, m_arvalid, m_arready;
    logic [NM-1:0]     m_rvalid, m_rlast, m_rready;
    logic [NM*DW-1:0]  m_wdata, m_rdata;
    logic [NM*2-1:0]   m_bresp;
    logic [AW-1:0]     s_awaddr, s_araddr;
    logic [7:0]        s_awlen, s_arlen;
    logic [2:0]        s_awsize, s_arsize;
    logic              s_awvalid, s_awready, s_wvalid, s_wlast, s_wready;
    logic [DW-1:0]     s_wdata, s_rdata;
    logic [1:0]        s_bresp;
    logic              s_bvalid, s_bready, s_arvalid, s_arready;
    logic              s_rvalid, s_rlast, s_rready;
    logic [0:0]        wr_gnt, rd_gnt;
    logic              wr_busy, rd_busy;

    axi4_full_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_M(NM)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rready(s_rready),
        .wr_gnt(wr_gnt), .rd_gnt(rd_gnt), .wr_busy(wr_busy), .rd_busy(rd_busy)
    );

    always #5 ACLK = ~ACLK;

    int check_count = 0;
    int pass_count  = 0;

    // Master-side transaction state
    bit          w_active[NM], aw_pend[NM], wv_hold[NM];
    logic [31:0] w_addr[NM];
    int          w_len[NM], w_beat[NM];
    logic [31:0] w_data[NM][16];
    bit          r_active[NM], ar_pend[NM];
    logic [31:0] r_addr[NM];
    int          r_len[NM], r_beat[NM], rd_done[NM];

    // Path ownership: -1 = free; *_prev is the last master served
    int wr_owner, rd_owner, wr_prev, rd_prev, wr_gnt_exp, rd_gnt_exp;
    int aw_gnt_hist[$];

    // Slave memory and its channel state
    logic [31:0] mem[MEM_WORDS];
    logic [31:0] ref_mem[MEM_WORDS];
    bit          sw_active, sb_pend, sr_active, srv_hold;
    int          sw_word, sw_len, sw_beat, sr_word, sr_len, sr_beat;
    logic [1:0]  sb_resp;
    bit          allow_new;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    endtask

    function automatic logic [31:0] rd_pattern(input int word);
        return (32'(word) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic int rrModel(input logic [NM-1:0] req, input int last);
        for (int k = 1; k <= NM; k++)
            if (req[(last + k) % NM]) return (last + k) % NM;
        return -1;
    endfunction

    function automatic bit anyActive();
        bit a;
        a = (wr_owner >= 0) || (rd_owner >= 0) || sb_pend || sr_active;
        for (int m = 0; m < NM; m++) a = a || w_active[m] || r_active[m];
        return a;
    endfunction

    task automatic resetModels();
        for (int m = 0; m < NM; m++) begin
            w_active[m] = 0; aw_pend[m] = 0; wv_hold[m] = 0; w_len[m] = 0; w_beat[m] = 0;
            r_active[m] = 0; ar_pend[m] = 0; r_len[m] = 0; r_beat[m] = 0;
            w_addr[m] = '0; r_addr[m] = '0;
        end
        wr_owner = -1; rd_owner = -1; wr_prev = NM - 1; rd_prev = NM - 1;
        wr_gnt_exp = 0; rd_gnt_exp = 0;
        sw_active = 0; sb_pend = 0; sr_active = 0; srv_hold = 0; sb_resp = 2'b00;
        for (int w = 0; w < MEM_WORDS; w++) begin
            mem[w]     = (w >= RD_BASE) ? rd_pattern(w) : 32'h0;
            ref_mem[w] = mem[w];
        end
    endtask

    task automatic startWrite(input int m, input int len, input logic [31:0] addr);
        w_active[m] = 1; aw_pend[m] = 1; wv_hold[m] = 0;
        w_len[m] = len; w_beat[m] = 0; w_addr[m] = addr;
        for (int b = 0; b < 16; b++) w_data[m][b] = $urandom;
    endtask

    task automatic startRead(input int m, input int len, input logic [31:0] addr);
        r_active[m] = 1; ar_pend[m] = 1; r_len[m] = len; r_beat[m] = 0; r_addr[m] = addr;
    endtask

    // Drives every master and slave input from the agents' current state
    task automatic applyStimulus();
        for (int m = 0; m < NM; m++) begin
            m_awvalid[m]          = aw_pend[m];
            m_awaddr[m*AW +: AW]  = w_addr[m];
            m_awlen[m*8 +: 8]     = 8'(w_len[m]);
            m_awsize[m*3 +: 3]    = 3'd2;
            if (w_active[m] && w_beat[m] <= w_len[m] && !wv_hold[m] && $urandom_range(0, 3) != 0)
                wv_hold[m] = 1;
            m_wvalid[m]           = wv_hold[m];
            m_wdata[m*DW +: DW]   = w_data[m][w_beat[m] % 16];
            m_wlast[m]            = (w_beat[m] == w_len[m]);
            m_bready[m]           = 1'($urandom_range(0, 1));
            m_arvalid[m]          = ar_pend[m];
            m_araddr[m*AW +: AW]  = r_addr[m];
            m_arlen[m*8 +: 8]     = 8'(r_len[m]);
            m_arsize[m*3 +: 3]    = 3'd2;
            m_rready[m]           = ($urandom_range(0, 2) != 0);
        end
        s_awready = ($urandom_range(0, 2) != 0);
        s_wready  = ($urandom_range(0, 2) != 0);
        s_bvalid  = sb_pend;
        s_bresp   = sb_pend ? sb_resp : 2'b00;
        s_arready = ($urandom_range(0, 2) != 0);
        if (sr_active && !srv_hold && $urandom_range(0, 3) != 0) srv_hold = 1;
        s_rvalid  = srv_hold;
        s_rdata   = srv_hold ? mem[(sr_word + sr_beat) % MEM_WORDS] : 32'h0;
        s_rlast   = srv_hold && (sr_beat == sr_len);
    endtask

    task automatic checkCycle();
        int               o, ro, word;
        bit               aw_ph, w_ph, b_ph, ar_ph, r_ph;
        logic [NM-1:0]    exp_v;
        logic [NM*DW-1:0] exp_d;
        logic [NM*2-1:0]  exp_b;
        o  = wr_owner;
        ro = rd_owner;
        aw_ph = (o >= 0) ? aw_pend[o] : 1'b0;
        w_ph  = (o >= 0) ? (!aw_pend[o] && w_beat[o] <= w_len[o]) : 1'b0;
        b_ph  = (o >= 0) ? (!aw_pend[o] && w_beat[o] > w_len[o]) : 1'b0;
        ar_ph = (ro >= 0) ? ar_pend[ro] : 1'b0;
        r_ph  = (ro >= 0) ? (!ar_pend[ro] && r_beat[ro] <= r_len[ro]) : 1'b0;

        checkOutput("wr_busy", 64'(wr_busy), 64'(o >= 0));
        checkOutput("wr_gnt", 64'(wr_gnt), 64'(wr_gnt_exp));
        checkOutput("s_awvalid", 64'(s_awvalid), 64'(aw_ph));
        exp_v = aw_ph ? (NM'(s_awready) << o) : '0;
        checkOutput("m_awready", 64'(m_awready), 64'(exp_v));
        if (aw_ph) begin
            checkOutput("s_awaddr", 64'(s_awaddr), 64'(w_addr[o]));
            checkOutput("s_awlen", 64'(s_awlen), 64'(w_len[o]));
        end
        checkOutput("s_wvalid", 64'(s_wvalid), w_ph ? 64'(m_wvalid[o]) : 64'd0);
        exp_v = w_ph ? (NM'(s_wready) << o) : '0;
        checkOutput("m_wready", 64'(m_wready), 64'(exp_v));
        if (w_ph && m_wvalid[o]) begin
            checkOutput("s_wdata", 64'(s_wdata), 64'(w_data[o][w_beat[o]]));
            checkOutput("s_wlast", 64'(s_wlast), 64'(w_beat[o] == w_len[o]));
        end
        checkOutput("s_bready", 64'(s_bready), b_ph ? 64'(m_bready[o]) : 64'd0);
        exp_v = b_ph ? (NM'(s_bvalid) << o) : '0;
        checkOutput("m_bvalid", 64'(m_bvalid), 64'(exp_v));
        exp_b = b_ph ? ((NM*2)'(s_bresp) << (2 * o)) : '0;
        checkOutput("m_bresp", 64'(m_bresp), 64'(exp_b));

        checkOutput("rd_busy", 64'(rd_busy), 64'(ro >= 0));
        checkOutput("rd_gnt", 64'(rd_gnt), 64'(rd_gnt_exp));
        checkOutput("s_arvalid", 64'(s_arvalid), 64'(ar_ph));
        exp_v = ar_ph ? (NM'(s_arready) << ro) : '0;
        checkOutput("m_arready", 64'(m_arready), 64'(exp_v));
        if (ar_ph) checkOutput("s_araddr", 64'(s_araddr), 64'(r_addr[ro]));
        checkOutput("s_rready", 64'(s_rready), r_ph ? 64'(m_rready[ro]) : 64'd0);
        exp_v = r_ph ? (NM'(s_rvalid) << ro) : '0;
        checkOutput("m_rvalid", 64'(m_rvalid), 64'(exp_v));
        exp_d = r_ph ? ((NM*DW)'(s_rdata) << (DW * ro)) : '0;
        checkOutput("m_rdata", 64'(m_rdata), 64'(exp_d));

        // Ownership changes take effect at the coming clock edge
        if (o >= 0) begin
            if (b_ph && m_bvalid[o] && m_bready[o]) begin
                wr_prev = o; wr_owner = -1;
            end
        end else if (|m_awvalid) begin
            wr_owner = rrModel(m_awvalid, wr_prev); wr_gnt_exp = wr_owner;
        end
        if (ro >= 0) begin
            if (r_ph && m_rvalid[ro] && m_rready[ro] && r_beat[ro] == r_len[ro]) begin
                rd_prev = ro; rd_owner = -1;
            end
        end else if (|m_arvalid) begin
            rd_owner = rrModel(m_arvalid, rd_prev); rd_gnt_exp = rd_owner;
        end

        for (int m = 0; m < NM; m++) begin
            if (m_awvalid[m] && m_awready[m]) aw_pend[m] = 0;
            if (m_wvalid[m] && m_wready[m]) begin
                w_beat[m]++; wv_hold[m] = 0;
            end
            if (m_bvalid[m] && m_bready[m]) begin
                for (int b = 0; b <= w_len[m]; b++)
                    ref_mem[(int'(w_addr[m] >> 2) + b) % MEM_WORDS] = w_data[m][b];
                w_active[m] = 0;
            end
            if (m_arvalid[m] && m_arready[m]) ar_pend[m] = 0;
            if (m_rvalid[m] && m_rready[m]) begin
                word = int'(r_addr[m] >> 2) + r_beat[m];
                checkOutput("rdata_beat", 64'(m_rdata[m*DW +: DW]), 64'(rd_pattern(word)));
                checkOutput("rlast_beat", 64'(m_rlast[m]), 64'(r_beat[m] == r_len[m]));
                if (r_beat[m] == r_len[m]) begin
                    r_active[m] = 0; rd_done[m]++;
                end
                r_beat[m]++;
            end
        end

        if (s_wvalid && s_wready) begin
            checkOutput("slave_w_after_aw", 64'(sw_active), 64'd1);
            mem[(sw_word + sw_beat) % MEM_WORDS] = s_wdata;
            sw_beat++;
            if (s_wlast) begin
                sw_active = 0; sb_pend = 1; sb_resp = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
            end
        end
        if (s_awvalid && s_awready) begin
            sw_active = 1; sw_word = int'(s_awaddr >> 2); sw_len = int'(s_awlen); sw_beat = 0;
            aw_gnt_hist.push_back(int'(wr_gnt));
        end
        if (s_bvalid && s_bready) sb_pend = 0;
        if (s_rvalid && s_rready) begin
            srv_hold = 0;
            if (sr_beat == sr_len) sr_active = 0;
            sr_beat++;
        end
        if (s_arvalid && s_arready) begin
            sr_active = 1; sr_word = int'(s_araddr >> 2); sr_len = int'(s_arlen); sr_beat = 0;
        end

        if (allow_new) begin
            for (int m = 0; m < NM; m++) begin
                if (!w_active[m] && $urandom_range(0, 5) == 0)
                    startWrite(m, $urandom_range(0, 7), 32'((m * 64 + int'($urandom_range(0, 48))) * 4));
                if (!r_active[m] && $urandom_range(0, 5) == 0)
                    startRead(m, $urandom_range(0, 7), 32'((RD_BASE + int'($urandom_range(0, 240))) * 4));
            end
        end
    endtask

    task automatic cycleStep();
        @(negedge ACLK);
        applyStimulus();
        #1;
        checkCycle();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (anyActive() && n < 500) begin
            cycleStep();
            n++;
        end
        checkOutput(tag, 64'(anyActive()), 64'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valids"}, 64'({s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}), 64'd0);
        checkOutput({tag, "_m_ready"}, 64'({m_awready, m_wready, m_arready}), 64'd0);
        checkOutput({tag, "_m_rvalid"}, 64'({m_rvalid, m_rlast, m_bvalid}), 64'd0);
        checkOutput({tag, "_m_data"}, 64'(m_rdata) | 64'(m_bresp), 64'd0);
        checkOutput({tag, "_busy_gnt"}, 64'({wr_busy, rd_busy, wr_gnt, rd_gnt}), 64'd0);
    endtask

    initial begin
        int  n, done_before;
        bit  found;
        ARESET = 1'b1;
        allow_new = 0;
        for (int m = 0; m < NM; m++) rd_done[m] = 0;
        resetModels();
        applyStimulus();
        @(negedge ACLK);
        #1;
        checkResetOutputs("reset");
        @(posedge ACLK);
        #2 ARESET = 1'b0;

        $display("[TB] directed: simultaneous writes plus concurrent M1 read");
        startWrite(0, 3, 32'h10);
        startWrite(1, 3, 32'((64 + 8) * 4));
        startRead(1, 7, 32'((RD_BASE + 16) * 4));
        drain("drain_directed1");
        startWrite(0, int'($urandom_range(0, 7)), 32'(32 * 4));
        startWrite(1, int'($urandom_range(0, 7)), 32'((64 + 32) * 4));
        drain("drain_directed2");
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("aw_gnt_seq%0d", i),
                        (aw_gnt_hist.size() > i) ? 64'(aw_gnt_hist[i]) : 64'hFFFF, 64'(i % 2));
        checkOutput("mem_word4", 64'(mem[4]), 64'(ref_mem[4]));

        $display("[TB] random traffic");
        allow_new = 1;
        repeat (2000) cycleStep();

        $display("[TB] reset in the middle of a read burst");
        found = 0;
        n = 0;
        while (!found && n < 600) begin
            cycleStep();
            n++;
            if (rd_owner >= 0)
                found = !ar_pend[rd_owner] && r_beat[rd_owner] == 1;
        end
        checkOutput("mid_burst_reached", 64'(found), 64'd1);
        @(negedge ACLK);
        applyStimulus();
        ARESET = 1'b1;
        #1;
        checkResetOutputs("midrst");
        resetModels();
        @(posedge ACLK);
        #2 ARESET = 1'b0;
        allow_new = 0;
        done_before = rd_done[0];
        startRead(0, 3, 32'((RD_BASE + 40) * 4));
        drain("drain_post_reset");
        checkOutput("post_reset_read", 64'(rd_done[0] - done_before), 64'd1);

        allow_new = 1;
        repeat (1000) cycleStep();
        allow_new = 0;
        drain("drain_final");
        for (int w = 0; w < 128; w++)
            checkOutput($sformatf("mem[%0d]", w), 64'(mem[w]), 64'(ref_mem[w]));

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
